// File: rtl/axi_mst_read_mb_pkg.sv
// axi_mst_read_mb_pkg
// Shared definitions for the multi-burst AXI4 read master:
//   state_t      - control FSM states
//   BOUNDARY_4K  - AXI burst address boundary in bytes
//   axsize()     - AR SIZE code for a given beat width in bytes
package axi_mst_read_mb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CALC,
      S_ADDR,
      S_DRAIN,
      S_END
   } state_t;

   localparam int unsigned BOUNDARY_4K = 4096;

   // log2 of the beat width in bytes; bytes is a power of two in 1..128
   function automatic logic [2:0] axsize(input int unsigned bytes);
      logic [2:0] s;
      s = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if ((32'd1 << i) == bytes) s = 3'(i);
      end
      return s;
   endfunction

endpackage

// File: rtl/fifo_axi_fwft.sv
// fifo_axi_fwft
// Single-clock first-word-fall-through FIFO. dout shows the head entry
// whenever empty is low; a write becomes visible on dout the next cycle.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (pointers/count)
//   wr_en, din    write strobe and data (ignored while full)
//   rd_en, dout   pop strobe and head data (ignored while empty)
//   full, empty   status flags
//   count         current number of stored entries
module fifo_axi_fwft #(
   parameter int B = 64,
   parameter int N = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [B-1:0]         din,
   input  logic                 rd_en,
   output logic [B-1:0]         dout,
   output logic                 full,
   output logic                 empty,
   output logic [$clog2(N):0]   count
);

   localparam int CW = $clog2(N);
   localparam int AW = (N > 1) ? CW : 1;
   localparam logic [CW:0]   FULL_CNT = (CW + 1)'(N);
   localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

   logic [B-1:0]  mem [N];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;

   // storage carries data only, so it is left out of reset
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
         count <= count + (CW + 1)'(do_wr) - (CW + 1)'(do_rd);
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/axi_mst_read_mb.sv
// axi_mst_read_mb
// Multi-burst AXI4 read master. A START_REG request reads LENGTH_REG beats
// from ADDR_REG as INCR bursts of at most MAX_BURST beats that never cross
// a 4 kB boundary, with up to MAX_OUTSTANDING bursts in flight. Read data
// goes through a FWFT FIFO to an AXI-Stream master; TLAST marks the final
// beat of the request.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   m_axi_ar*         AXI4 read address channel (ARID 0, INCR, SIZE = beat width)
//   m_axi_r*          AXI4 read data channel (RID ignored)
//   m_axis_t*         AXI-Stream master (TSTRB all ones)
//   START_REG         level request, one transfer per high period
//   ADDR_REG          start byte address (beat aligned), sampled in LOAD
//   LENGTH_REG        total beats, sampled in LOAD
//   RIDLE_REG         high while idle
//   RERR_REG          sticky error: an RRESP other than OKAY since last start
//   probe             five 32-bit statistics words, driven only when
//                     AXI_MST_READ_MB_STATS_EN is defined, else tied to 0
module axi_mst_read_mb
   import axi_mst_read_mb_pkg::*;
#(
   parameter int ID_WIDTH        = 6,
   parameter int DATA_WIDTH      = 64,
   parameter int MAX_BURST       = 16,
   parameter int FIFO_DEPTH      = 64,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [ID_WIDTH-1:0]     m_axi_arid,
   output logic [31:0]             m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic [1:0]              m_axi_arlock,
   output logic [3:0]              m_axi_arcache,
   output logic [2:0]              m_axi_arprot,
   output logic [3:0]              m_axi_arqos,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [ID_WIDTH-1:0]     m_axi_rid,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rlast,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   output logic                    m_axis_tvalid,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   input  logic                    START_REG,
   input  logic [31:0]             ADDR_REG,
   input  logic [31:0]             LENGTH_REG,
   output logic                    RIDLE_REG,
   output logic                    RERR_REG,
   output logic [5*32-1:0]         probe
);

   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int BSHIFT = $clog2(BYTES);
   localparam int CW     = $clog2(FIFO_DEPTH);
   localparam int RW     = CW + 1;
   localparam int OW     = $clog2(MAX_OUTSTANDING + 1);

   state_t          state;
   logic [31:0]     addr_r;
   logic [31:0]     remain_r;
   logic [31:0]     len_r;
   logic [31:0]     beat_cnt;
   logic [8:0]      burst_n;
   logic [7:0]      arlen_r;
   logic            arvalid_r;
   logic            rerr_r;
   logic [RW-1:0]   reserved;
   logic [OW-1:0]   outstanding;
   logic [CW:0]     fifo_count;
   logic            fifo_full;
   logic            fifo_empty;
   logic [12:0]     room_bytes;
   logic [31:0]     room_beats;
   logic [31:0]     n_calc;
   logic            credit_ok;
   logic            out_ok;
   logic            ar_hs;
   logic            r_hs;
   logic            t_hs;
   logic            unused;

   assign ar_hs = arvalid_r & m_axi_arready;
   assign r_hs  = m_axi_rvalid & m_axi_rready;
   assign t_hs  = m_axis_tvalid & m_axis_tready;

   // burst size: limited by what is left, MAX_BURST and the 4 kB page
   assign room_bytes = 13'(BOUNDARY_4K) - {1'b0, addr_r[11:0]};
   assign room_beats = 32'(room_bytes >> BSHIFT);

   always_comb begin
      n_calc = remain_r;
      if (n_calc > 32'(MAX_BURST)) n_calc = 32'(MAX_BURST);
      if (n_calc > room_beats)     n_calc = room_beats;
   end

   // a burst is only requested once the FIFO is certain to hold all of it
   assign credit_ok = (32'(fifo_count) + 32'(reserved) + n_calc) <= 32'(FIFO_DEPTH);
   assign out_ok    = 32'(outstanding) < 32'(MAX_OUTSTANDING);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         addr_r    <= '0;
         remain_r  <= '0;
         len_r     <= '0;
         burst_n   <= '0;
         arlen_r   <= '0;
         arvalid_r <= 1'b0;
         rerr_r    <= 1'b0;
      end else begin
         if (r_hs && (m_axi_rresp != 2'b00)) rerr_r <= 1'b1;
         case (state)
            S_IDLE: begin
               if (START_REG) state <= S_LOAD;
            end
            S_LOAD: begin
               addr_r   <= ADDR_REG;
               remain_r <= LENGTH_REG;
               len_r    <= LENGTH_REG;
               rerr_r   <= 1'b0;
               state    <= (LENGTH_REG == 32'd0) ? S_END : S_CALC;
            end
            S_CALC: begin
               if (out_ok && credit_ok) begin
                  burst_n   <= n_calc[8:0];
                  arlen_r   <= 8'(n_calc - 32'd1);
                  arvalid_r <= 1'b1;
                  state     <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (m_axi_arready) begin
                  arvalid_r <= 1'b0;
                  addr_r    <= addr_r + (32'(burst_n) << BSHIFT);
                  remain_r  <= remain_r - 32'(burst_n);
                  state     <= (remain_r == 32'(burst_n)) ? S_DRAIN : S_CALC;
               end
            end
            S_DRAIN: begin
               if (outstanding == '0) state <= S_END;
            end
            S_END: begin
               if (!START_REG) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // credit and in-flight tracking; increment and decrement may coincide
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reserved    <= '0;
         outstanding <= '0;
         beat_cnt    <= '0;
      end else begin
         reserved    <= reserved + (ar_hs ? RW'(burst_n) : RW'(0)) - RW'(r_hs);
         outstanding <= outstanding + OW'(ar_hs) - OW'(r_hs & m_axi_rlast);
         if (state == S_LOAD) beat_cnt <= '0;
         else if (t_hs)       beat_cnt <= beat_cnt + 32'd1;
      end
   end

   fifo_axi_fwft #(
      .B (DATA_WIDTH),
      .N (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (r_hs),
      .din   (m_axi_rdata),
      .rd_en (t_hs),
      .dout  (m_axis_tdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign m_axi_arid    = '0;
   assign m_axi_araddr  = addr_r;
   assign m_axi_arlen   = arlen_r;
   assign m_axi_arsize  = axsize(BYTES);
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = '0;
   assign m_axi_arcache = '0;
   assign m_axi_arprot  = '0;
   assign m_axi_arqos   = '0;
   assign m_axi_arvalid = arvalid_r;
   // full gating is a backstop; the credit check already prevents overflow
   assign m_axi_rready  = (state != S_IDLE) && (state != S_LOAD) && !fifo_full;

   assign m_axis_tvalid = ~fifo_empty;
   assign m_axis_tstrb  = '1;
   assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == (len_r - 32'd1));

   assign RIDLE_REG = (state == S_IDLE);
   assign RERR_REG  = rerr_r;

`ifdef AXI_MST_READ_MB_STATS_EN
   logic [31:0] st_ar;
   logic [31:0] st_addr;
   logic [31:0] st_req;
   logic [31:0] st_beats;
   logic [31:0] st_cyc;
   logic [31:0] run_cyc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_ar    <= '0;
         st_addr  <= '0;
         st_req   <= '0;
         st_beats <= '0;
         st_cyc   <= '0;
         run_cyc  <= '0;
      end else begin
         if (ar_hs) begin
            st_ar   <= st_ar + 32'd1;
            st_addr <= addr_r;
         end
         if (r_hs) st_beats <= st_beats + 32'd1;
         // run_cyc counts the LOAD cycle as 1; the DRAIN exit cycle is added on latch
         if (state == S_LOAD)
            run_cyc <= 32'd1;
         else if (state inside {S_CALC, S_ADDR, S_DRAIN})
            run_cyc <= run_cyc + 32'd1;
         if (state == S_DRAIN && outstanding == '0) st_cyc <= run_cyc + 32'd1;
         if ((state == S_DRAIN && outstanding == '0) ||
             (state == S_LOAD && LENGTH_REG == 32'd0))
            st_req <= st_req + 32'd1;
      end
   end

   assign probe = {st_cyc, st_beats, st_req, st_addr, st_ar};
`else
   assign probe = '0;
`endif

   assign unused = ^{m_axi_rid, n_calc[31:9]};

endmodule
